// File: rtl/seg7_scan_mux_pkg.sv
// Shared constants and the active-low hex-to-segment table for the 7-segment scan driver.
package seg7_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Segments are active-low, packed {G,F,E,D,C,B,A}
  function automatic logic [6:0] hex2seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = SEG_OFF;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_scan_mux_if.sv
// Core-side data/control and board-side pin bundle for seg7_scan_mux.
// bright_i exists only when SEG7_DIM_EN is defined.
interface seg7_scan_mux_if #(
  parameter int N_DIGITS = 8
);
  logic [4*N_DIGITS-1:0] data_i;
  logic [N_DIGITS-1:0]   dp_i;
  logic [N_DIGITS-1:0]   en_i;
  logic                  blank_lz_i;
`ifdef SEG7_DIM_EN
  logic [3:0]            bright_i;
`endif
  logic [6:0]            seg_o;
  logic                  dp_o;
  logic [N_DIGITS-1:0]   an_o;
  logic                  frame_o;

`ifdef SEG7_DIM_EN
  modport master (output data_i, dp_i, en_i, blank_lz_i, bright_i,
                  input  seg_o, dp_o, an_o, frame_o);
  modport slave  (input  data_i, dp_i, en_i, blank_lz_i, bright_i,
                  output seg_o, dp_o, an_o, frame_o);
`else
  modport master (output data_i, dp_i, en_i, blank_lz_i,
                  input  seg_o, dp_o, an_o, frame_o);
  modport slave  (input  data_i, dp_i, en_i, blank_lz_i,
                  output seg_o, dp_o, an_o, frame_o);
`endif

endinterface

// File: rtl/seg7_scan_mux_hex_decode.sv
// Combinational nibble to active-low segment pattern.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = hex2seg(nib);

endmodule

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed N-digit common-anode 7-segment driver with per-frame snapshot,
// inter-digit blanking and leading-zero suppression. SEG7_DIM_EN adds PWM brightness.
module seg7_scan_mux
  import seg7_pkg::*;
#(
  parameter int N_DIGITS       = 8,
  parameter int REFRESH_CLOCKS = 200_000,
  parameter int BLANK_CLOCKS   = 2_000
) (
  input  logic          clk,
  input  logic          rst_ni,
  seg7_scan_mux_if.slave bus
);

  // Counter is at least 4 bits so the PWM gate can always look at cnt[3:0]
  localparam int CNT_W = ($clog2(REFRESH_CLOCKS) < 4) ? 4 : $clog2(REFRESH_CLOCKS);
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_CLOCKS - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CLOCKS);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_DIGITS - 1);

  logic [CNT_W-1:0]      cnt_p0;
  logic [IDX_W-1:0]      idx_p0;
  logic                  first_p0;
  logic [4*N_DIGITS-1:0] sh_data_p0;
  logic [N_DIGITS-1:0]   sh_dp_p0;
  logic [N_DIGITS-1:0]   sh_en_p0;
  logic                  sh_lz_p0;

  logic                  slot_end;
  logic                  snap;
  logic [IDX_W-1:0]      hi_idx;
  logic [3:0]            cur_nib;
  logic [6:0]            dec_seg;
  logic                  vld_p0;

  logic [N_DIGITS-1:0]   an_p1;
  logic [6:0]            seg_p1;
  logic                  dp_p1;
  logic                  frame_p1;

  assign slot_end = (cnt_p0 == CNT_LAST);
  // first_p0 forces a snapshot on the first clock after reset release
  assign snap     = first_p0 || (slot_end && (idx_p0 == IDX_LAST));

  // ---- stage p0: slot counter, digit index, frame shadow ----
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_p0   <= '0;
      idx_p0   <= '0;
      first_p0 <= 1'b1;
    end else begin
      first_p0 <= 1'b0;
      cnt_p0   <= slot_end ? '0 : cnt_p0 + 1'b1;
      if (slot_end) begin
        idx_p0 <= (idx_p0 == IDX_LAST) ? '0 : idx_p0 + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      sh_data_p0 <= '0;
      sh_dp_p0   <= '0;
      sh_en_p0   <= '0;
      sh_lz_p0   <= 1'b0;
    end else if (snap) begin
      sh_data_p0 <= bus.data_i;
      sh_dp_p0   <= bus.dp_i;
      sh_en_p0   <= bus.en_i;
      sh_lz_p0   <= bus.blank_lz_i;
    end
  end

  // Highest nonzero nibble; digit 0 stays eligible even when everything is zero
  always_comb begin
    hi_idx = '0;
    for (int k = 1; k < N_DIGITS; k++) begin
      if (sh_data_p0[4*k +: 4] != 4'h0) hi_idx = IDX_W'(k);
    end
  end

  assign cur_nib = sh_data_p0[{idx_p0, 2'b00} +: 4];

  seg7_hex_decode u_dec (
    .nib (cur_nib),
    .seg (dec_seg)
  );

  always_comb begin
    vld_p0 = sh_en_p0[idx_p0]
          && !(sh_lz_p0 && (idx_p0 > hi_idx))
          && (cnt_p0 >= CNT_BLANK);
`ifdef SEG7_DIM_EN
    vld_p0 = vld_p0 && (cnt_p0[3:0] < bus.bright_i);
`endif
  end

  // ---- stage p1: registered pin drivers ----
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      an_p1    <= '1;
      seg_p1   <= SEG_OFF;
      dp_p1    <= 1'b1;
      frame_p1 <= 1'b0;
    end else begin
      frame_p1 <= snap;
      if (vld_p0) begin
        an_p1  <= ~(N_DIGITS'(1) << idx_p0);
        seg_p1 <= dec_seg;
        dp_p1  <= ~sh_dp_p0[idx_p0];
      end else begin
        an_p1  <= '1;
        seg_p1 <= SEG_OFF;
        dp_p1  <= 1'b1;
      end
    end
  end

  assign bus.an_o    = an_p1;
  assign bus.seg_o   = seg_p1;
  assign bus.dp_o    = dp_p1;
  assign bus.frame_o = frame_p1;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Bench for seg7_scan_mux (N_DIGITS=6, REFRESH_CLOCKS=8, BLANK_CLOCKS=2): directed scenarios
// plus randomized inputs, checked every cycle against a time-based behavioural model.
module tb_seg7_scan_mux;

  localparam int N = 6;
  localparam int R = 8;
  localparam int B = 2;
  localparam int P = N * R;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  seg7_scan_mux_if #(.N_DIGITS(N)) ifc ();

  seg7_scan_mux #(
    .N_DIGITS       (N),
    .REFRESH_CLOCKS (R),
    .BLANK_CLOCKS   (B)
  ) dut (
    .clk    (clk),
    .rst_ni (rst_n),
    .bus    (ifc)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Model: e = clock edges since reset release; state before edge e+1 is time step e
  int          e;
  logic [23:0] m_data;
  logic [5:0]  m_dp, m_en;
  logic        m_lz;
  logic [5:0]  x_an;
  logic [6:0]  x_seg;
  logic        x_dp, x_frame;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e       <= 0;
      m_data  <= '0;
      m_dp    <= '0;
      m_en    <= '0;
      m_lz    <= 1'b0;
      x_an    <= 6'h3F;
      x_seg   <= 7'h7F;
      x_dp    <= 1'b1;
      x_frame <= 1'b0;
    end else begin : model
      automatic int   pos   = e % R;
      automatic int   digit = (e / R) % N;
      automatic int   hi    = 0;
      automatic logic on;
      automatic logic snap_now = (e == 0) || (((e + 1) % P) == 0);
      for (int k = 0; k < N; k++) if (m_data[4*k +: 4] != 4'h0) hi = k;
      on = m_en[digit] && !(m_lz && (digit > hi)) && (pos >= B);
`ifdef SEG7_DIM_EN
      on = on && ((pos % 16) < int'(ifc.bright_i));
`endif
      x_an    <= on ? ~(6'(1) << digit) : 6'h3F;
      x_seg   <= on ? seg_tab[m_data[4*digit +: 4]] : 7'h7F;
      x_dp    <= on ? ~m_dp[digit] : 1'b1;
      x_frame <= snap_now;
      if (snap_now) begin
        m_data <= ifc.data_i;
        m_dp   <= ifc.dp_i;
        m_en   <= ifc.en_i;
        m_lz   <= ifc.blank_lz_i;
      end
      e <= e + 1;
    end
  end

  always @(negedge clk) begin
    check("an_o",    32'(ifc.an_o),    32'(x_an));
    check("seg_o",   32'(ifc.seg_o),   32'(x_seg));
    check("dp_o",    32'(ifc.dp_o),    32'(x_dp));
    check("frame_o", 32'(ifc.frame_o), 32'(x_frame));
  end

  task automatic goto_edge(input int n);
    int guard = 0;
    while (e != n && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    tests++;
    if (e != n) begin
      fails++;
      $display("FAIL goto_edge: reached edge %0d, expected %0d", e, n);
    end
  endtask

  initial begin
    rst_n          = 1'b1;
    ifc.data_i     = 24'h123456;
    ifc.en_i       = 6'h3F;
    ifc.dp_i       = 6'h00;
    ifc.blank_lz_i = 1'b0;
`ifdef SEG7_DIM_EN
    ifc.bright_i   = 4'd15;
`endif
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_an",    32'(ifc.an_o),    32'h3F);
    check("rst_seg",   32'(ifc.seg_o),   32'h7F);
    check("rst_dp",    32'(ifc.dp_o),    32'h1);
    check("rst_frame", 32'(ifc.frame_o), 32'h0);
    #2 rst_n = 1'b1;

    // Scan after release
    goto_edge(1);  check("first_frame", 32'(ifc.frame_o), 32'h1);
                   check("blank1_an",   32'(ifc.an_o),    32'h3F);
    goto_edge(2);  check("blank2_an",   32'(ifc.an_o),    32'h3F);
    goto_edge(3);  check("d0_an",       32'(ifc.an_o),    32'h3E);
                   check("d0_seg",      32'(ifc.seg_o),   32'h02);
    goto_edge(43); check("d5_an",       32'(ifc.an_o),    32'h1F);
                   check("d5_seg",      32'(ifc.seg_o),   32'h79);
    goto_edge(48); check("period_frame",32'(ifc.frame_o), 32'h1);
    goto_edge(51); check("wrap_d0_an",  32'(ifc.an_o),    32'h3E);

    // Leading-zero suppression
    #2 ifc.data_i = 24'h0000A0; ifc.blank_lz_i = 1'b1;
    goto_edge(99);  check("lz_d0_an",  32'(ifc.an_o),  32'h3E);
                    check("lz_d0_seg", 32'(ifc.seg_o), 32'h40);
    goto_edge(107); check("lz_d1_an",  32'(ifc.an_o),  32'h3D);
                    check("lz_d1_seg", 32'(ifc.seg_o), 32'h08);
    goto_edge(115); check("lz_d2_an",  32'(ifc.an_o),  32'h3F);
    #2 ifc.data_i = 24'h000000;
    goto_edge(147); check("zero_d0_an",  32'(ifc.an_o),  32'h3E);
                    check("zero_d0_seg", 32'(ifc.seg_o), 32'h40);
    goto_edge(155); check("zero_d1_an",  32'(ifc.an_o),  32'h3F);

    // No tearing when data changes mid-frame
    #2 ifc.data_i = 24'h111111; ifc.blank_lz_i = 1'b0;
    goto_edge(220);
    #2 ifc.data_i = 24'h222222;
    goto_edge(235); check("tear_d5_an",  32'(ifc.an_o),  32'h1F);
                    check("tear_d5_seg", 32'(ifc.seg_o), 32'h79);
    goto_edge(243); check("new_d0_seg",  32'(ifc.seg_o), 32'h24);

    // Per-digit enable and decimal point
    #2 ifc.en_i = 6'b000010; ifc.dp_i = 6'b000010;
    goto_edge(291); check("en_d0_an",  32'(ifc.an_o),  32'h3F);
    goto_edge(299); check("en_d1_an",  32'(ifc.an_o),  32'h3D);
                    check("en_d1_dp",  32'(ifc.dp_o),  32'h0);
                    check("en_d1_seg", 32'(ifc.seg_o), 32'h24);
    goto_edge(307); check("en_d2_an",  32'(ifc.an_o),  32'h3F);

    // Asynchronous reset in the middle of digit 4
    goto_edge(324);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check("arst_an",  32'(ifc.an_o),  32'h3F);
       check("arst_seg", 32'(ifc.seg_o), 32'h7F);
       check("arst_dp",  32'(ifc.dp_o),  32'h1);
    ifc.data_i = 24'h654321; ifc.en_i = 6'h3F; ifc.dp_i = 6'h00;
    @(negedge clk);
    #2 rst_n = 1'b1;
    goto_edge(1); check("rearm_frame",  32'(ifc.frame_o), 32'h1);
    goto_edge(3); check("rearm_d0_an",  32'(ifc.an_o),    32'h3E);
                  check("rearm_d0_seg", 32'(ifc.seg_o),   32'h79);

    // Randomized traffic, including one reset pulse
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      #2;
      if ($urandom_range(0, 19) == 0)
        ifc.data_i = 24'($urandom) & (24'hFFFFFF >> (4 * $urandom_range(0, 6)));
      if ($urandom_range(0, 29) == 0) begin
        ifc.en_i       = 6'($urandom);
        ifc.dp_i       = 6'($urandom);
        ifc.blank_lz_i = 1'($urandom_range(0, 1));
      end
`ifdef SEG7_DIM_EN
      if ($urandom_range(0, 49) == 0) ifc.bright_i = 4'($urandom);
`endif
      if (i == 700) rst_n = 1'b0;
      if (i == 701) rst_n = 1'b1;
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
